// File: rtl/ef_wb_pkg.sv
// rtl/ef_wb_pkg.sv - shared Wishbone types and helpers for EF WB initiator and peripherals
package ef_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    function automatic int wb_sel_w(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/ef_wb_initiator.sv
// rtl/ef_wb_initiator.sv - single-beat Wishbone classic initiator with bounded ack wait
module ef_wb_initiator
    import ef_wb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_we,
    input  logic [AW-1:0]            cmd_addr,
    input  logic [DW-1:0]            cmd_wdata,
    input  logic [wb_sel_w(DW)-1:0]  cmd_sel,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DW-1:0]            rsp_rdata,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [AW-1:0]            adr_o,
    output logic [DW-1:0]            dat_o,
    input  logic [DW-1:0]            dat_i,
    output logic [wb_sel_w(DW)-1:0]  sel_o,
    output logic                     we_o,
    output logic                     cyc_o,
    output logic                     stb_o,
    input  logic                     ack_i
);

    localparam int SW    = wb_sel_w(DW);
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    wb_state_e         state_q, state_d;
    logic [AW-1:0]     adr_q, adr_d;
    logic [DW-1:0]     dat_q, dat_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic              we_q, we_d;
    logic              cyc_q, cyc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    assign cmd_ready = (state_q == ST_IDLE) & ~rst_i;
    assign busy      = (state_q != ST_IDLE);
    assign adr_o     = adr_q;
    assign dat_o     = dat_q;
    assign sel_o     = sel_q;
    assign we_o      = we_q;
    assign cyc_o     = cyc_q;
    assign stb_o     = cyc_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        cyc_d       = cyc_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    adr_d   = cmd_addr;
                    dat_d   = cmd_wdata;
                    sel_d   = cmd_sel;
                    we_d    = cmd_we;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                // Ack is checked before the timeout so a last-cycle ack still completes normally.
                if (ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = we_q ? '0 : dat_i;
                    state_d     = ST_RESP;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = ST_RESP;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            cyc_q       <= cyc_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_ef_wb_initiator.sv
// tb/tb_ef_wb_initiator.sv - directed bench for ef_wb_initiator with a delayed-ack WB responder
module tb_ef_wb_initiator;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [31:0]   cmd_addr, cmd_wdata;
    logic [3:0]    cmd_sel;
    logic          rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0]   rsp_rdata;
    logic [31:0]   adr_o, dat_o, dat_i;
    logic [3:0]    sel_o;
    logic          we_o, cyc_o, stb_o, ack_i;

    always #5 clk_i = ~clk_i;

    ef_wb_initiator #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .sel_o(sel_o),
        .we_o(we_o), .cyc_o(cyc_o), .stb_o(stb_o), .ack_i(ack_i)
    );

    // Responder: 16-word register file, ack raised after ack_delay cycles of cyc_o.
    logic [31:0] mem [0:15];
    int          wcnt;
    int          ack_delay;

    assign ack_i = cyc_o && stb_o && (wcnt == ack_delay);
    assign dat_i = mem[adr_o[5:2]];

    always @(posedge clk_i) begin
        if (!cyc_o) wcnt <= 0;
        else        wcnt <= wcnt + 1;
        if (rst_i) begin
            for (int w = 0; w < 16; w++) mem[w] <= '0;
        end else if (cyc_o && stb_o && ack_i && we_o) begin
            for (int b = 0; b < 4; b++)
                if (sel_o[b]) mem[adr_o[5:2]][8*b +: 8] <= dat_o[8*b +: 8];
        end
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the attached peripheral and of the current transaction.
    logic [31:0] model_mem [0:15];
    logic        exp_we, exp_err, in_flight;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_sel;
    int          cyc_total = 0;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            chk("stb_eq_cyc", stb_o, cyc_o);
            chk("cmd_ready_vs_busy", cmd_ready, !busy);
            if (cyc_o) begin
                cyc_total <= cyc_total + 1;
                if (!in_flight) chk("spurious_cyc", cyc_o, 1'b0);
                else begin
                    chk("adr_o", adr_o, exp_addr);
                    chk("we_o", we_o, exp_we);
                    chk("sel_o", sel_o, exp_sel);
                    if (exp_we) chk("dat_o", dat_o, exp_wdata);
                end
            end
            if (rsp_valid) begin
                if (!in_flight) chk("spurious_rsp", rsp_valid, 1'b0);
                else begin
                    chk("rsp_rdata", rsp_rdata, exp_rdata);
                    chk("rsp_err", rsp_err, exp_err);
                    chk("cyc_in_resp", cyc_o, 1'b0);
                end
            end
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  sel;
        int          dly;
        int          hold;
        logic        hv;
        int          lcyc;
        logic        lerr;
        logic [31:0] lrd;
    } vec_t;

    vec_t vt [0:7];

    task automatic run_vec(input vec_t v);
        int k;
        int cyc_start;
        int exp_cyc;
        exp_err   = (v.dly >= TO);
        exp_cyc   = exp_err ? TO : v.dly + 1;
        exp_rdata = (exp_err || v.we) ? 32'h0 : model_mem[v.a[5:2]];
        exp_we    = v.we;
        exp_addr  = v.a;
        exp_wdata = v.d;
        exp_sel   = v.sel;
        ack_delay = v.dly;
        in_flight = 1'b1;
        @(posedge clk_i); #1;
        cmd_valid = 1'b1; cmd_we = v.we; cmd_addr = v.a; cmd_wdata = v.d; cmd_sel = v.sel;
        rsp_ready = (v.hold == 0);
        k = 0;
        forever begin
            @(negedge clk_i);
            if (cmd_ready) break;
            k++;
            if (k > 20) begin chk("accept_timeout", 1, 0); cmd_valid = 1'b0; return; end
        end
        cyc_start = cyc_total;
        @(posedge clk_i); #1;
        if (!v.hv) cmd_valid = 1'b0;
        k = 0;
        forever begin
            @(negedge clk_i);
            if (rsp_valid) break;
            k++;
            if (k > 40) begin chk("rsp_timeout", 1, 0); cmd_valid = 1'b0; return; end
        end
        chk("model_cyc_count", cyc_total - cyc_start, exp_cyc);
        chk("lit_cyc_count", cyc_total - cyc_start, v.lcyc);
        chk("lit_rsp_err", rsp_err, v.lerr);
        chk("lit_rsp_rdata", rsp_rdata, v.lrd);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk_i);
            chk("hold_rsp_valid", rsp_valid, 1'b1);
            chk("hold_cmd_ready", cmd_ready, 1'b0);
            chk("hold_no_cyc", cyc_o, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        in_flight = 1'b0;
        if (v.we && !exp_err)
            for (int b = 0; b < 4; b++)
                if (v.sel[b]) model_mem[v.a[5:2]][8*b +: 8] = v.d[8*b +: 8];
        @(negedge clk_i);
        chk("post_rsp_valid", rsp_valid, 1'b0);
        chk("post_busy", busy, 1'b0);
    endtask

    task automatic reset_mid_cycle();
        int k;
        exp_we = 1'b0; exp_addr = 32'h8; exp_wdata = 32'h0; exp_sel = 4'hF;
        exp_err = 1'b0; exp_rdata = 32'h0;
        ack_delay = 1000;
        in_flight = 1'b1;
        @(posedge clk_i); #1;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h8; cmd_sel = 4'hF; rsp_ready = 1'b1;
        @(posedge clk_i); #1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("pre_reset_cyc", cyc_o, 1'b1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        in_flight = 1'b0;
        for (int w = 0; w < 16; w++) model_mem[w] = '0;
        chk("reset_drops_cyc", cyc_o, 1'b0);
        chk("reset_drops_stb", stb_o, 1'b0);
        k = 0;
        repeat (10) begin
            @(negedge clk_i);
            if (rsp_valid || cyc_o) k++;
        end
        chk("no_rsp_after_reset", k, 0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        vt[0] = '{1'b1, 32'h0, 32'h0000_00A5, 4'hF, 1,   0, 1'b0, 2, 1'b0, 32'h0};
        vt[1] = '{1'b0, 32'h0, 32'h0,         4'hF, 2,   0, 1'b0, 3, 1'b0, 32'h0000_00A5};
        vt[2] = '{1'b1, 32'h0, 32'h0000_00FF, 4'hF, 255, 0, 1'b0, 8, 1'b1, 32'h0};
        vt[3] = '{1'b0, 32'h0, 32'h0,         4'hF, 7,   0, 1'b0, 8, 1'b0, 32'h0000_00A5};
        vt[4] = '{1'b1, 32'h4, 32'h1122_3344, 4'h3, 0,   5, 1'b1, 1, 1'b0, 32'h0};
        vt[5] = '{1'b0, 32'h4, 32'h0,         4'hF, 0,   0, 1'b0, 1, 1'b0, 32'h0000_3344};
        vt[6] = '{1'b0, 32'h0, 32'h0,         4'hF, 0,   0, 1'b0, 1, 1'b0, 32'h0};
        vt[7] = '{1'b0, 32'h4, 32'h0,         4'hF, 255, 2, 1'b0, 8, 1'b1, 32'h0};
        for (int w = 0; w < 16; w++) model_mem[w] = '0;
        in_flight = 1'b0; ack_delay = 0;
        exp_we = 0; exp_err = 0; exp_addr = 0; exp_wdata = 0; exp_rdata = 0; exp_sel = 0;
        rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_sel = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_cyc", cyc_o, 1'b0);
        chk("rst_we", we_o, 1'b0);
        chk("rst_adr", adr_o, 32'h0);
        chk("rst_sel", sel_o, 4'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        rst_i = 1'b0;
        #1;
        chk("idle_cmd_ready", cmd_ready, 1'b1);
        for (int i = 0; i < 6; i++) run_vec(vt[i]);
        reset_mid_cycle();
        run_vec(vt[6]);
        run_vec(vt[7]);
        repeat (2) @(posedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
